// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store stage: packet layouts,
// funct3 encodings, state encoding and the write-back packet builder.
package lsu_pkg;

  localparam int EXU_W = 109;
  localparam int WB_W  = 104;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_SEND = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_ren;
    logic        mem_wen;
    logic [2:0]  funct3;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [1:0]  rd_input_sel;
    logic [31:0] csr_data;
  } exu_pkt_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [1:0]  rd_input_sel;
    logic [31:0] csr_data;
  } wb_pkt_t;

  function automatic wb_pkt_t make_wb(input exu_pkt_t p, input logic [31:0] ld);
    wb_pkt_t w;
    w.alu_result   = p.alu_result;
    w.load_data    = ld;
    w.rd_wen       = p.rd_wen;
    w.rd_addr      = p.rd_addr;
    w.rd_input_sel = p.rd_input_sel;
    w.csr_data     = p.csr_data;
    return w;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store strobes/data placement and load extraction
// with sign or zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = mem_rdata >> {off, 3'b000};
    wdata     = store_data << {off, 3'b000};
    wmask     = 4'b0000;
    load_data = shifted;

    // Misaligned halfwords simply lose the strobes shifted past lane 3.
    case (funct3)
      F3_SB:   wmask = 4'b0001 << off;
      F3_SH:   wmask = 4'b0011 << off;
      F3_SW:   wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase

    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_data = {24'h0, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: accepts one execute packet, performs at most one memory
// access, and emits a single-cycle write-back pulse (no back-pressure downstream).
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exu_valid,
  output logic             exu_ready,
  input  logic [EXU_W-1:0] exu_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             lsu_valid,
  output logic [WB_W-1:0]  lsu_data,
  output logic [1:0]       dbg_state
);

  // Handshakes: exu side transfers when exu_valid && exu_ready; the memory
  // side holds mem_req and its qualifiers stable until the mem_ack cycle;
  // lsu_valid is a one-cycle pulse with no ready.

  lsu_state_e  state;
  exu_pkt_t    pkt_q;
  exu_pkt_t    in_pkt;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic [31:0] ld_sel;

  assign in_pkt    = exu_pkt_t'(exu_data);
  assign exu_ready = (state == S_IDLE);
  assign dbg_state = state;

  lsu_align u_align (
    .off        (pkt_q.alu_result[1:0]),
    .funct3     (pkt_q.funct3),
    .store_data (pkt_q.store_data),
    .mem_rdata  (mem_rdata),
    .wmask      (al_wmask),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  // Store wins when both enables are set.
  assign ld_sel    = (pkt_q.mem_ren && !pkt_q.mem_wen) ? al_load : 32'h0;

  assign mem_we    = mem_req & pkt_q.mem_wen;
  assign mem_addr  = mem_req ? pkt_q.alu_result : 32'h0;
  assign mem_wdata = mem_we  ? al_wdata : 32'h0;
  assign mem_wmask = mem_we  ? al_wmask : 4'b0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pkt_q     <= '0;
      mem_req   <= 1'b0;
      lsu_valid <= 1'b0;
      lsu_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          lsu_valid <= 1'b0;
          if (exu_valid) begin
            pkt_q <= in_pkt;
            if (in_pkt.mem_ren || in_pkt.mem_wen) begin
              state   <= S_MEM;
              mem_req <= 1'b1;
            end else begin
              state     <= S_SEND;
              lsu_valid <= 1'b1;
              lsu_data  <= make_wb(in_pkt, 32'h0);
            end
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            state     <= S_SEND;
            mem_req   <= 1'b0;
            lsu_valid <= 1'b1;
            lsu_data  <= make_wb(pkt_q, ld_sel);
          end
        end
        S_SEND: begin
          state     <= S_IDLE;
          lsu_valid <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          mem_req   <= 1'b0;
          lsu_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: inputs driven and outputs checked on the
// falling edge, expected values hand-derived per vector.
module tb_lsu_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         exu_valid;
  logic         exu_ready;
  logic [108:0] exu_data;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wmask;
  logic [31:0]  mem_rdata;
  logic         mem_ack;
  logic         lsu_valid;
  logic [103:0] lsu_data;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_stage #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .exu_valid (exu_valid),
    .exu_ready (exu_ready),
    .exu_data  (exu_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .lsu_valid (lsu_valid),
    .lsu_data  (lsu_data),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [108:0] mk_pkt(input logic [31:0] alu, input logic [31:0] sd,
                                          input logic ren, input logic wen, input logic [2:0] f3,
                                          input logic rdw, input logic [4:0] rda,
                                          input logic [1:0] sel, input logic [31:0] csr);
    return {alu, sd, ren, wen, f3, rdw, rda, sel, csr};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Accept pkt, ack in the ack_at-th MEM cycle, then check the pulse and return to idle.
  task automatic run_mem(input string tag, input logic [108:0] pkt, input int ack_at,
                         input logic [31:0] rdata, input logic exp_we, input logic [3:0] exp_mask,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_load);
    logic [103:0] exp_wb;
    exp_wb = {pkt[108:77], exp_load, pkt[39:0]};
    check({tag, ".ready"}, exu_ready, 1'b1);
    exu_valid = 1'b1;
    exu_data  = pkt;
    step();
    exu_valid = 1'b0;
    for (int k = 1; k <= ack_at; k++) begin
      check({tag, ".req"},   mem_req, 1'b1);
      check({tag, ".we"},    mem_we, exp_we);
      check({tag, ".addr"},  mem_addr, pkt[108:77]);
      check({tag, ".mask"},  mem_wmask, exp_mask);
      check({tag, ".wdata"}, mem_wdata, exp_wdata);
      check({tag, ".novld"}, lsu_valid, 1'b0);
      if (k == ack_at) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = ~rdata;
      end
      step();
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    check({tag, ".vld"},    lsu_valid, 1'b1);
    check({tag, ".reqoff"}, mem_req, 1'b0);
    check({tag, ".wb"},     lsu_data, exp_wb);
    step();
    check({tag, ".pulse"},  lsu_valid, 1'b0);
    check({tag, ".idle"},   exu_ready, 1'b1);
    check({tag, ".hold"},   lsu_data, exp_wb);
  endtask

  initial begin
    logic [108:0] pa;
    logic [108:0] pb;

    rst       = 1'b0;
    exu_valid = 1'b0;
    exu_data  = '0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
    step();
    step();
    check("rst.req",   mem_req, 1'b0);
    check("rst.we",    mem_we, 1'b0);
    check("rst.addr",  mem_addr, 32'h0);
    check("rst.wdata", mem_wdata, 32'h0);
    check("rst.mask",  mem_wmask, 4'h0);
    check("rst.vld",   lsu_valid, 1'b0);
    check("rst.data",  lsu_data, 104'h0);
    check("rst.state", dbg_state, 2'd0);
    rst = 1'b1;
    step();
    check("rst.ready", exu_ready, 1'b1);

    // Stray ack while idle must be ignored.
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("ackidle.vld",   lsu_valid, 1'b0);
    check("ackidle.ready", exu_ready, 1'b1);

    // Non-memory packet.
    check("nm.ready0", exu_ready, 1'b1);
    exu_valid = 1'b1;
    exu_data  = mk_pkt(32'h1234, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd5, 2'b01, 32'hCAFE);
    step();
    exu_valid = 1'b0;
    check("nm.vld",   lsu_valid, 1'b1);
    check("nm.req",   mem_req, 1'b0);
    check("nm.ready1", exu_ready, 1'b0);
    check("nm.alu",   lsu_data[103:72], 32'h1234);
    check("nm.load",  lsu_data[71:40], 32'h0);
    check("nm.rd",    lsu_data[38:34], 5'd5);
    check("nm.wb",    lsu_data, {32'h1234, 32'h0, 1'b1, 5'd5, 2'b01, 32'hCAFE});
    step();
    check("nm.pulse", lsu_valid, 1'b0);
    check("nm.ready2", exu_ready, 1'b1);

    run_mem("lb",  mk_pkt(32'h1003, 32'h0, 1'b1, 1'b0, 3'b000, 1'b1, 5'd7, 2'b10, 32'h1),
            3, 32'h80FF_0000, 1'b0, 4'h0, 32'h0, 32'hFFFF_FF80);
    run_mem("lbu", mk_pkt(32'h1003, 32'h0, 1'b1, 1'b0, 3'b100, 1'b1, 5'd7, 2'b10, 32'h1),
            3, 32'h80FF_0000, 1'b0, 4'h0, 32'h0, 32'h0000_0080);
    run_mem("sh",  mk_pkt(32'h2002, 32'hABCD, 1'b0, 1'b1, 3'b001, 1'b0, 5'd0, 2'b00, 32'h0),
            2, 32'hDEAD_BEEF, 1'b1, 4'b1100, 32'hABCD_0000, 32'h0);
    run_mem("lw0", mk_pkt(32'h0, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd9, 2'b01, 32'h0),
            1, 32'h1234_5678, 1'b0, 4'h0, 32'h0, 32'h1234_5678);
    run_mem("lh",  mk_pkt(32'h0002, 32'h0, 1'b1, 1'b0, 3'b001, 1'b1, 5'd3, 2'b01, 32'h0),
            1, 32'h8001_7F00, 1'b0, 4'h0, 32'h0, 32'hFFFF_8001);
    run_mem("lhu", mk_pkt(32'h0002, 32'h0, 1'b1, 1'b0, 3'b101, 1'b1, 5'd3, 2'b01, 32'h0),
            2, 32'h8001_7F00, 1'b0, 4'h0, 32'h0, 32'h0000_8001);
    run_mem("sb",  mk_pkt(32'h0101, 32'h1234_565A, 1'b0, 1'b1, 3'b000, 1'b0, 5'd0, 2'b00, 32'h0),
            1, 32'h0, 1'b1, 4'b0010, 32'h3456_5A00, 32'h0);
    run_mem("shm", mk_pkt(32'h0003, 32'h0000_BEEF, 1'b0, 1'b1, 3'b001, 1'b0, 5'd0, 2'b00, 32'h0),
            1, 32'h0, 1'b1, 4'b1000, 32'hEF00_0000, 32'h0);
    run_mem("lwm", mk_pkt(32'h0001, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd4, 2'b01, 32'h0),
            1, 32'hAABB_CCDD, 1'b0, 4'h0, 32'h0, 32'h00AA_BBCC);
    run_mem("both", mk_pkt(32'h0004, 32'h1122_3344, 1'b1, 1'b1, 3'b010, 1'b1, 5'd6, 2'b01, 32'h0),
            2, 32'hFFFF_FFFF, 1'b1, 4'b1111, 32'h1122_3344, 32'h0);

    // Back-pressure: exu_valid held through the access, second packet waits.
    pa = mk_pkt(32'h0010, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd1, 2'b01, 32'h0);
    pb = mk_pkt(32'h0777, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd2, 2'b11, 32'h55);
    exu_valid = 1'b1;
    exu_data  = pa;
    step();
    exu_data  = pb;
    check("bp.ready1", exu_ready, 1'b0);
    check("bp.req1",   mem_req, 1'b1);
    step();
    check("bp.ready2", exu_ready, 1'b0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack   = 1'b0;
    check("bp.vldA",   lsu_valid, 1'b1);
    check("bp.readyA", exu_ready, 1'b0);
    check("bp.wbA",    lsu_data, {32'h0010, 32'h0BAD_F00D, pa[39:0]});
    step();
    check("bp.readyB", exu_ready, 1'b1);
    check("bp.gap",    lsu_valid, 1'b0);
    step();
    exu_valid = 1'b0;
    check("bp.vldB",   lsu_valid, 1'b1);
    check("bp.wbB",    lsu_data, {32'h0777, 32'h0, pb[39:0]});
    step();
    check("bp.pulseB", lsu_valid, 1'b0);
    step();
    check("bp.once",   lsu_valid, 1'b0);
    check("bp.idle",   exu_ready, 1'b1);

    // Reset in the middle of a memory access.
    exu_valid = 1'b1;
    exu_data  = mk_pkt(32'h0020, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd8, 2'b01, 32'h0);
    step();
    exu_valid = 1'b0;
    check("mr.req", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1 check("mr.reqdrop", mem_req, 1'b0);
    check("mr.state", dbg_state, 2'd0);
    step();
    mem_ack = 1'b1;
    check("mr.novld", lsu_valid, 1'b0);
    rst = 1'b1;
    step();
    mem_ack = 1'b0;
    check("mr.ready", exu_ready, 1'b1);
    check("mr.novld2", lsu_valid, 1'b0);
    step();
    check("mr.novld3", lsu_valid, 1'b0);
    check("mr.req2",   mem_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
